// File: rtl/ql_ctrl_multi_if.sv
// Bundle of run configuration, stage enables and status for ql_ctrl_multi.
// With QL_CTRL_PAUSE_EN defined the bundle also carries the pause input.
interface ql_ctrl_multi_if #(
  parameter int N_AGENT = 2,
  parameter int STATE_W = 12,
  parameter int ACT_W   = 2,
  parameter int CNT_W   = 16
);
  // start is a level, not a valid/ready pair: high while idle launches a run,
  // and it must fall after DONE before the controller returns to IDLE.
  logic                       start;
  logic [CNT_W-1:0]           max_step;
  logic [CNT_W-1:0]           max_episode;
  logic [15:0]                seed;
  logic [15:0]                eps_init;
  logic [3:0]                 eps_shift;
`ifdef QL_CTRL_PAUSE_EN
  logic                       pause;
`endif
  logic                       SD;
  logic                       PG;
  logic                       RD;
  logic                       QA;
  logic                       wen;
  logic [N_AGENT-1:0]         asel;
  logic [N_AGENT*ACT_W-1:0]   arand;
  logic [N_AGENT*STATE_W-1:0] s0;
  logic                       idle;
  logic                       finish;
  logic [CNT_W-1:0]           dbg_sc;
  logic [CNT_W-1:0]           dbg_ec;
  logic [2:0]                 dbg_cs;
  logic [15:0]                dbg_eps;

  modport master (
`ifdef QL_CTRL_PAUSE_EN
    input  pause,
`endif
    input  start, max_step, max_episode, seed, eps_init, eps_shift,
    output SD, PG, RD, QA, wen, asel, arand, s0, idle, finish,
    output dbg_sc, dbg_ec, dbg_cs, dbg_eps
  );

  modport slave (
`ifdef QL_CTRL_PAUSE_EN
    output pause,
`endif
    output start, max_step, max_episode, seed, eps_init, eps_shift,
    input  SD, PG, RD, QA, wen, asel, arand, s0, idle, finish,
    input  dbg_sc, dbg_ec, dbg_cs, dbg_eps
  );
endinterface

// File: rtl/ql_ctrl_multi.sv
// Multi-agent Q-learning episode sequencer: stage enables, per-agent LFSR
// exploration, geometric epsilon decay. Optional pause via QL_CTRL_PAUSE_EN.
module ql_ctrl_multi #(
  parameter int N_AGENT = 2,
  parameter int STATE_W = 12,
  parameter int ACT_W   = 2,
  parameter int CNT_W   = 16
) (
  input logic            clk,
  input logic            rst,
  ql_ctrl_multi_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_FILL  = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_EPEND = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         sub_q, sub_d;
  logic [CNT_W-1:0]   sc_q, sc_d;
  logic [CNT_W-1:0]   ec_q, ec_d;
  logic [15:0]        eps_q, eps_d;
  logic               finish_q;
  logic [3:0]         en;
  logic               hold;
  logic               ep_more;

  logic [15:0]        lfsr_q  [N_AGENT];
  logic               asel_q  [N_AGENT];
  logic [ACT_W-1:0]   arand_q [N_AGENT];
  logic [STATE_W-1:0] s0_q    [N_AGENT];

  // Agents are decorrelated by a golden-ratio offset; zero would lock the LFSR.
  function automatic logic [15:0] lfsr_load(input logic [15:0] s, input int idx);
    logic [15:0] v;
    v = s ^ 16'(idx * 32'h9E37);
    return (v == 16'h0000) ? 16'h0001 : v;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

`ifdef QL_CTRL_PAUSE_EN
  assign hold = bus.pause &&
                (state_q == S_FILL || state_q == S_RUN || state_q == S_DRAIN);
`else
  assign hold = 1'b0;
`endif

  assign ep_more = (ec_q < bus.max_episode);

  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    sc_d    = sc_q;
    ec_d    = ec_q;
    eps_d   = eps_q;
    en      = 4'b0000;
    if (!hold) begin
      case (state_q)
        S_IDLE: begin
          sc_d  = '0;
          ec_d  = '0;
          eps_d = bus.eps_init;
          if (bus.start) state_d = S_INIT;
        end
        S_INIT: begin
          sc_d  = '0;
          sub_d = '0;
          state_d = ep_more ? S_FILL : S_DONE;
        end
        S_FILL: begin
          // Pipeline fills one stage every two cycles.
          case (sub_q[2:1])
            2'd0:    en = 4'b1000;
            2'd1:    en = 4'b1100;
            default: en = 4'b1110;
          endcase
          if (sub_q == 3'd5) begin
            sub_d   = '0;
            state_d = S_RUN;
          end else begin
            sub_d = sub_q + 3'd1;
          end
        end
        S_RUN: begin
          en   = (sc_q == '0) ? 4'b1111 : 4'b0111;
          sc_d = sc_q + CNT_W'(1);
          if (sc_q == bus.max_step) begin
            sub_d   = '0;
            state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          en = sub_q[1] ? 4'b0001 : 4'b0011;
          if (sub_q == 3'd3) begin
            sub_d   = '0;
            state_d = S_EPEND;
          end else begin
            sub_d = sub_q + 3'd1;
          end
        end
        S_EPEND: begin
          ec_d    = (&ec_q) ? ec_q : ec_q + CNT_W'(1);
          eps_d   = eps_q - (eps_q >> bus.eps_shift);
          state_d = S_INIT;
        end
        S_DONE: begin
          if (!bus.start) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sub_q    <= '0;
      sc_q     <= '0;
      ec_q     <= '0;
      eps_q    <= '0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sub_q    <= sub_d;
      sc_q     <= sc_d;
      ec_q     <= ec_d;
      eps_q    <= eps_d;
      finish_q <= (state_d == S_DONE) && (state_q != S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_AGENT; i++) begin
      if (rst) begin
        lfsr_q[i]  <= lfsr_load(bus.seed, i);
        asel_q[i]  <= 1'b0;
        arand_q[i] <= '0;
        s0_q[i]    <= '0;
      end else begin
        if (state_q == S_IDLE) begin
          lfsr_q[i] <= lfsr_load(bus.seed, i);
        end else if (!hold) begin
          lfsr_q[i] <= lfsr_step(lfsr_q[i]);
        end
        if (!hold) begin
          asel_q[i]  <= !(eps_q > lfsr_q[i]);
          arand_q[i] <= lfsr_q[i][ACT_W-1:0];
        end
        if (state_q == S_INIT && ep_more) begin
          s0_q[i] <= lfsr_q[i][STATE_W:1];
        end
      end
    end
  end

  always_comb begin
    bus.asel  = '0;
    bus.arand = '0;
    bus.s0    = '0;
    for (int i = 0; i < N_AGENT; i++) begin
      bus.asel[i]                  = asel_q[i];
      bus.arand[i*ACT_W +: ACT_W]  = arand_q[i];
      bus.s0[i*STATE_W +: STATE_W] = s0_q[i];
    end
  end

  assign bus.SD      = en[3];
  assign bus.PG      = en[2];
  assign bus.RD      = en[1];
  assign bus.QA      = en[0];
  assign bus.wen     = !hold && (state_q == S_RUN || state_q == S_DRAIN);
  assign bus.idle    = (state_q == S_IDLE);
  assign bus.finish  = finish_q;
  assign bus.dbg_sc  = sc_q;
  assign bus.dbg_ec  = ec_q;
  assign bus.dbg_cs  = state_q;
  assign bus.dbg_eps = eps_q;

endmodule

// File: tb/tb_ql_ctrl_multi.sv
// Directed bench for ql_ctrl_multi: reset values, full two-episode trace,
// LFSR seeding, empty run, reset mid-RUN and (with QL_CTRL_PAUSE_EN) pause.
module tb_ql_ctrl_multi;
  localparam int N_AGENT = 2;
  localparam int STATE_W = 12;
  localparam int ACT_W   = 2;
  localparam int CNT_W   = 16;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] exp_q[$];

  ql_ctrl_multi_if #(.N_AGENT(N_AGENT), .STATE_W(STATE_W), .ACT_W(ACT_W), .CNT_W(CNT_W)) bus ();

  ql_ctrl_multi #(.N_AGENT(N_AGENT), .STATE_W(STATE_W), .ACT_W(ACT_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] en_now();
    return {bus.SD, bus.PG, bus.RD, bus.QA};
  endfunction

  task automatic wait_cs(input logic [2:0] cs, input int budget, input string tag);
    int n = 0;
    while (bus.dbg_cs != cs && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.dbg_cs), 32'(cs));
  endtask

  task automatic set_cfg(input logic [15:0] ms, input logic [15:0] me, input logic [15:0] sd,
                         input logic [15:0] eps, input logic [3:0] sh);
    bus.max_step    = ms;
    bus.max_episode = me;
    bus.seed        = sd;
    bus.eps_init    = eps;
    bus.eps_shift   = sh;
  endtask

  initial begin
    int c0;
    int wen_cnt [2];
    int fin_cnt;
    int init_at[$];
    logic [3:0] ep_trace [15];

    ep_trace = '{4'h8, 4'h8, 4'hC, 4'hC, 4'hE, 4'hE, 4'hF, 4'h7, 4'h7, 4'h7,
                 4'h3, 4'h3, 4'h1, 4'h1, 4'h0};

    // Clock/reset
    rst = 1'b1;
    bus.start = 1'b0;
`ifdef QL_CTRL_PAUSE_EN
    bus.pause = 1'b0;
`endif
    set_cfg(16'd3, 16'd2, 16'h0000, 16'hFFFF, 4'd1);
    tick();
    tick();
    chk("rst_idle",   32'(bus.idle),    32'd1);
    chk("rst_cs",     32'(bus.dbg_cs),  32'd0);
    chk("rst_en",     32'(en_now()),    32'd0);
    chk("rst_wen",    32'(bus.wen),     32'd0);
    chk("rst_sc",     32'(bus.dbg_sc),  32'd0);
    chk("rst_ec",     32'(bus.dbg_ec),  32'd0);
    chk("rst_eps",    32'(bus.dbg_eps), 32'd0);
    chk("rst_asel",   32'(bus.asel),    32'd0);
    chk("rst_arand",  32'(bus.arand),   32'd0);
    chk("rst_s0",     32'(bus.s0),      32'd0);
    chk("rst_finish", 32'(bus.finish),  32'd0);
    rst = 1'b0;
    tick();
    chk("idle_eps", 32'(bus.dbg_eps), 32'hFFFF);

    // Two episodes of max_step=3: INIT + 15 per episode, final INIT, then DONE.
    for (int ep = 0; ep < 2; ep++) begin
      exp_q.push_back(32'h0);
      for (int k = 0; k < 15; k++) exp_q.push_back(32'(ep_trace[k]));
    end
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);

    wen_cnt = '{0, 0};
    fin_cnt = 0;
    bus.start = 1'b1;
    tick();
    chk("run_init", 32'(bus.dbg_cs), 32'd1);
    for (int c = 0; c < 34; c++) begin
      chk("en_trace", 32'(en_now()), exp_q.pop_front());
      if (bus.dbg_cs == 3'd1) init_at.push_back(c);
      if (bus.wen && c < 32) wen_cnt[c / 16]++;
      if (bus.finish) fin_cnt++;
      if (c == 1) begin
        chk("s0_seed0",  32'(bus.s0),    32'hF1B000);
        chk("arand_c1",  32'(bus.arand), 32'hD);
      end
      if (c == 2) chk("arand_c2", 32'(bus.arand), 32'hC);
      if (c == 3) chk("arand_c3", 32'(bus.arand), 32'h4);
      if (c == 16) chk("eps_ep1", 32'(bus.dbg_eps), 32'h8000);
      if (c < 33) tick();
    end
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("done_cs",   32'(bus.dbg_cs),  32'd6);
    chk("done_ec",   32'(bus.dbg_ec),  32'd2);
    chk("done_eps",  32'(bus.dbg_eps), 32'h4000);
    chk("n_init",    32'(init_at.size()), 32'd3);
    if (init_at.size() == 3) begin
      chk("init_ep2",  32'(init_at[1]), 32'd16);
      // Last INIT falls 32 cycles after the first; DONE follows one cycle later.
      chk("init_last", 32'(init_at[2]), 32'd32);
    end
    chk("wen_ep1", 32'(wen_cnt[0]), 32'd8);
    chk("wen_ep2", 32'(wen_cnt[1]), 32'd8);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("done_hold", 32'(bus.dbg_cs), 32'd6);
      if (bus.finish) fin_cnt++;
    end
    chk("finish_once", 32'(fin_cnt), 32'd1);
    bus.start = 1'b0;
    tick();
    chk("done_to_idle", 32'(bus.idle), 32'd1);

    // max_episode=0: straight to DONE, no enables.
    set_cfg(16'd3, 16'd0, 16'h0000, 16'h8000, 4'd1);
    tick();
    tick();
    bus.start = 1'b1;
    tick();
    chk("me0_init", 32'(bus.dbg_cs), 32'd1);
    chk("me0_en0",  32'(en_now()),   32'd0);
    tick();
    chk("me0_done",   32'(bus.dbg_cs), 32'd6);
    chk("me0_finish", 32'(bus.finish), 32'd1);
    chk("me0_en1",    32'(en_now()),   32'd0);
    chk("me0_asel1",  32'(bus.asel),   32'h2);
    tick();
    chk("me0_fin_off", 32'(bus.finish), 32'd0);
    chk("me0_asel2",   32'(bus.asel),   32'h3);
    chk("me0_wen",     32'(bus.wen),    32'd0);
    bus.start = 1'b0;
    tick();
    chk("me0_idle", 32'(bus.idle), 32'd1);

    // Reset on the second RUN cycle.
    set_cfg(16'd3, 16'd2, 16'h1234, 16'hFFFF, 4'd1);
    bus.start = 1'b1;
    tick();
    wait_cs(3'd3, 20, "rr_reach_run");
    chk("rr_first_en", 32'(en_now()), 32'hF);
    tick();
    chk("rr_sc1", 32'(bus.dbg_sc), 32'd1);
    chk("rr_en2", 32'(en_now()),   32'h7);
    rst = 1'b1;
    tick();
    chk("rr_idle", 32'(bus.idle),   32'd1);
    chk("rr_en",   32'(en_now()),   32'd0);
    chk("rr_wen",  32'(bus.wen),    32'd0);
    chk("rr_sc",   32'(bus.dbg_sc), 32'd0);
    chk("rr_ec",   32'(bus.dbg_ec), 32'd0);
    rst = 1'b0;
    bus.start = 1'b0;
    tick();

`ifdef QL_CTRL_PAUSE_EN
    // Five-cycle pause on the second RUN cycle stretches the episode 16 -> 21.
    set_cfg(16'd3, 16'd1, 16'h0000, 16'hFFFF, 4'd1);
    bus.start = 1'b1;
    tick();
    c0 = cyc;
    wait_cs(3'd3, 20, "p_reach_run");
    tick();
    bus.pause = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("p_en",  32'(en_now()),   32'd0);
      chk("p_wen", 32'(bus.wen),    32'd0);
      chk("p_sc",  32'(bus.dbg_sc), 32'd1);
      tick();
    end
    bus.pause = 1'b0;
    chk("p_sc_after", 32'(bus.dbg_sc), 32'd1);
    chk("p_en_after", 32'(en_now()),   32'h7);
    wait_cs(3'd1, 40, "p_next_init");
    chk("p_ep_len", 32'(cyc - c0), 32'd21);
    tick();
    chk("p_done", 32'(bus.dbg_cs), 32'd6);
    bus.start = 1'b0;
    tick();
`else
    c0 = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
